karatsuba_mult_pipe: RTL and testbench
======================================

Name: karatsuba_mult_pipe

Overview:
- Next-generation pipelined Karatsuba multiplier for the FP/integer multiplier path.
- Accepts any WIDTH (odd or even) and a per-transaction signed/unsigned mode.
- Has a leaf-multiplier latency parameter, a sideband tag that travels with each operand pair, and full valid/ready backpressure. The whole pipeline stalls under backpressure; nothing is dropped.
- Sits between operand unpack and normalisation in the FP32/FP64 mantissa datapaths and in the integer MUL unit.

Parameters:
- WIDTH, 24, operand width in bits, >= 4; odd values allowed.
- LEAF_LAT, 2, register stages inside each leaf multiplier, >= 1.
- TAG_W, 4, width of the opaque sideband tag, >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  synchronous active-low reset.
- valid_i  in  1  input operand pair valid.
- ready_o  out  1  block can accept an input this cycle.
- signed_i  in  1  1 = operands are two's complement; 0 = unsigned.
- tag_i  in  TAG_W  sideband tag, returned unchanged with the result.
- multiplicand_i  in  WIDTH  operand A.
- multiplier_i  in  WIDTH  operand B.
- valid_o  out  1  product valid.
- ready_i  in  1  downstream accepts the product.
- tag_o  out  TAG_W  tag of the current product.
- product_o  out  2*WIDTH  full-precision product; two's complement when the originating signed_i was 1.

Behaviour:
- Reset: synchronous, sampled on the clk_i rising edge while rstn_i = 0.
  - Clears every stage valid bit, so valid_o = 0.
  - Clears product_o and tag_o to 0.
  - ready_o = 1 from the first cycle after reset releases.
  - Reset mid-operation discards all in-flight transactions silently.
- Split widths:
  - LO = WIDTH/2, rounded down; HI = WIDTH - LO; MID = HI + 1.
  - A = Ah*2^LO + Al, same split for B.
- Global advance: adv = !valid_o | ready_i, and ready_o = adv.
  - Every pipeline register, including the leaf registers, loads only when adv = 1. Otherwise all stages hold.
  - Bubbles are not collapsed.
  - An input is accepted when valid_i & ready_o.
- Stage S1 (abs/split/pre-add):
  - In signed mode, take magnitudes |A| and |B|, each held as an unsigned WIDTH-bit value. -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
  - Result sign = sign(A) XOR sign(B), forced to 0 when signed_i = 0.
  - Register Ah, Al, Bh, Bl, sumA = Ah + Al (MID bits), sumB, sign, tag and valid.
- Leaf stages (S2..S1+LEAF_LAT), three parallel unsigned multiplies:
  - Pl = Al*Bl, 2*LO bits.
  - Ph = Ah*Bh, 2*HI bits.
  - Pm = sumA*sumB, 2*MID bits.
  - Each has latency exactly LEAF_LAT. sign, tag and valid are delayed alongside.
- Stage S_a: register t = Pm - Ph. Delay Pl and Ph.
- Stage S_b:
  - Register M = t - Pl. This is always >= 0 and fits in 2*MID bits.
  - Delay Ph and Pl.
- Stage S_c: register mag = (Ph << 2*LO) + (M << LO) + Pl, truncated to 2*WIDTH bits. The truncation is exact: no overflow occurs for any input.
- Stage S_d (output register): product_o = sign ? -mag : mag, computed modulo 2^(2*WIDTH). tag_o and valid_o are registered here.
- Latency: LEAF_LAT + 5 cycles from acceptance to valid_o when ready_i stays high (7 at defaults).
- Throughput: 1 result/cycle when ready_i stays high.
- Output stability: while valid_o = 1 and ready_i = 0, product_o and tag_o hold constant.
- Simultaneous events:
  - An accept on the same cycle as an output consume is legal, since adv = 1.
  - An input presented while ready_o = 0 must be held by upstream and is not captured.
- Ordering: in-order; each tag is returned exactly once.
- Zero operands give product 0 with the result sign ignored, so negative zero never appears.

Decomposition:
- karatsuba_pkg holds:
  - Functions lo_w(w), hi_w(w), mid_w(w).
  - Function pipe_lat(leaf_lat) = leaf_lat + 5.
  - Typedef for the per-stage sideband struct {valid, sign, tag}, parameterised through TAG_W in the instantiating module.
- One sub-module: karatsuba_leaf_mul, with parameters AW and LAT.
  - Unsigned AW x AW multiply with LAT enable-gated register stages.
  - Port en_i is driven by adv.
  - Instantiated three times: twice with AW = LO/HI, once with AW = MID.

Test Plan:
1. Reset, then the first cycle after release: valid_o = 0, product_o = 0, ready_o = 1. Reset asserted mid-stream with 3 in flight: no valid_o afterwards.
2. WIDTH=24, unsigned 0xFFFFFF * 0xFFFFFF, tag 0x5 -> product_o = 0xFFFFFE000001, tag_o = 0x5, exactly 7 cycles after accept.
3. WIDTH=24, signed:
   - 0x800000 * 0x800000 -> 0x400000000000.
   - 0x800000 * 0x000001 -> 0xFFFFFF800000.
   - 0xFFFFFF * 0xFFFFFF -> 0x000000000001.
   - 0x000000 * 0xFFFFFF -> 0.
4. Back-to-back stream of 20 random pairs with mixed signed_i while ready_i toggles pseudo-randomly -> all 20 results match the golden model, in order, with correct tags. Outputs are held stable during every stall, and ready_o = 0 exactly when valid_o = 1 and ready_i = 0.
5. WIDTH=25, LEAF_LAT=3, unsigned 0x1FFFFFF * 0x1FFFFFF -> 0x3FFFFFC000001 after 8 cycles. Simultaneous accept and consume every cycle sustains 1 result/cycle.
6. Random regression, 10k vectors, for WIDTH in {8, 11, 24, 53} and both modes, compared against a behavioural $signed/$unsigned multiply.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// Shared width helpers for the pipelined Karatsuba multiplier.
package karatsuba_pkg;

    // Width of the low operand half (rounded down for odd widths).
    function automatic int unsigned lo_w(input int unsigned w);
        return w / 2;
    endfunction

    // Width of the high operand half; takes the extra bit for odd widths.
    function automatic int unsigned hi_w(input int unsigned w);
        return w - (w / 2);
    endfunction

    // Width of the pre-added half sums (one carry bit above the high half).
    function automatic int unsigned mid_w(input int unsigned w);
        return hi_w(w) + 1;
    endfunction

    // Register stages from the input capture to the output register inclusive.
    function automatic int unsigned pipe_lat(input int unsigned leaf_lat);
        return leaf_lat + 5;
    endfunction

endpackage

// File: rtl/karatsuba_mult_pipe_leaf_mul.sv
// Unsigned AW x AW multiplier followed by LAT enable-gated register stages.
module karatsuba_leaf_mul #(
    parameter int unsigned AW  = 12,
    parameter int unsigned LAT = 2
) (
    input  logic            clk_i,
    input  logic            en_i,
    input  logic [AW-1:0]   a_i,
    input  logic [AW-1:0]   b_i,
    output logic [2*AW-1:0] p_o
);

    localparam int unsigned PW = 2 * AW;

    logic [PW-1:0] pipe_d [LAT];
    logic [PW-1:0] pipe_q [LAT];

    // First stage takes the raw product, later stages shift it along.
    always_comb begin
        pipe_d[0] = PW'(a_i) * PW'(b_i);
        for (int unsigned i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Datapath only: validity is tracked by the caller's sideband pipe.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            pipe_q <= pipe_d;
        end
    end

    assign p_o = pipe_q[LAT-1];

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// Pipelined signed/unsigned Karatsuba multiplier with valid/ready and a sideband tag.
module karatsuba_mult_pipe
    import karatsuba_pkg::*;
#(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned LEAF_LAT = 2,
    parameter int unsigned TAG_W    = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               signed_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned LO  = lo_w(WIDTH);
    localparam int unsigned HI  = hi_w(WIDTH);
    localparam int unsigned MID = mid_w(WIDTH);
    localparam int unsigned NST = pipe_lat(LEAF_LAT);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned PLW = 2 * LO;
    localparam int unsigned PHW = 2 * HI;
    localparam int unsigned PMW = 2 * MID;

    // Sideband carried alongside every stage; declared here because the tag
    // width is a parameter of this module.
    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [TAG_W-1:0] tag;
    } side_t;

    side_t sb_d [NST];
    side_t sb_q [NST];

    // Whole pipe moves as one; bubbles are kept.
    logic adv;
    assign adv = !sb_q[NST-1].valid | ready_i;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [HI-1:0]    ah_d, ah_q, bh_d, bh_q;
    logic [LO-1:0]    al_d, al_q, bl_d, bl_q;
    logic [MID-1:0]   suma_d, suma_q, sumb_d, sumb_q;

    logic [PLW-1:0]   pl;
    logic [PHW-1:0]   ph;
    logic [PMW-1:0]   pm;

    logic [PMW-1:0]   t_d, t_q, m_d, m_q;
    logic [PLW-1:0]   pla_d, pla_q, plb_d, plb_q;
    logic [PHW-1:0]   pha_d, pha_q, phb_d, phb_q;
    logic [PW-1:0]    mag_d, mag_q, prod_d, prod_q;

    // S1: magnitudes, half split and pre-add. -2^(W-1) negates to 2^(W-1) unsigned.
    always_comb begin
        a_neg  = signed_i & multiplicand_i[WIDTH-1];
        b_neg  = signed_i & multiplier_i[WIDTH-1];
        a_mag  = a_neg ? -multiplicand_i : multiplicand_i;
        b_mag  = b_neg ? -multiplier_i : multiplier_i;
        ah_d   = a_mag[WIDTH-1:LO];
        al_d   = a_mag[LO-1:0];
        bh_d   = b_mag[WIDTH-1:LO];
        bl_d   = b_mag[LO-1:0];
        suma_d = MID'(ah_d) + MID'(al_d);
        sumb_d = MID'(bh_d) + MID'(bl_d);
    end

    // Sideband: stage 0 is S1, then leaf stages, then S_a, S_b, S_c, S_d.
    always_comb begin
        sb_d[0].valid = valid_i;
        sb_d[0].sign  = a_neg ^ b_neg;
        sb_d[0].tag   = tag_i;
        for (int unsigned i = 1; i < NST; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // Sideband registers; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < NST; i++) begin
                sb_q[i] <= '0;
            end
        end else if (adv) begin
            sb_q <= sb_d;
        end
    end

    karatsuba_leaf_mul #(.AW(LO), .LAT(LEAF_LAT)) u_leaf_lo (
        .clk_i (clk_i),
        .en_i  (adv),
        .a_i   (al_q),
        .b_i   (bl_q),
        .p_o   (pl)
    );

    karatsuba_leaf_mul #(.AW(HI), .LAT(LEAF_LAT)) u_leaf_hi (
        .clk_i (clk_i),
        .en_i  (adv),
        .a_i   (ah_q),
        .b_i   (bh_q),
        .p_o   (ph)
    );

    karatsuba_leaf_mul #(.AW(MID), .LAT(LEAF_LAT)) u_leaf_mid (
        .clk_i (clk_i),
        .en_i  (adv),
        .a_i   (suma_q),
        .b_i   (sumb_q),
        .p_o   (pm)
    );

    // Post-leaf recombination: cross term, then shifted sum, then sign restore.
    always_comb begin
        t_d    = pm - PMW'(ph);
        pla_d  = pl;
        pha_d  = ph;
        m_d    = t_q - PMW'(pla_q);
        plb_d  = pla_q;
        phb_d  = pha_q;
        mag_d  = (PW'(phb_q) << PLW) + (PW'(m_q) << LO) + PW'(plb_q);
        // Bubbles present zero so the output never shows stale data.
        if (!sb_q[NST-2].valid) begin
            prod_d = '0;
        end else if (sb_q[NST-2].sign) begin
            prod_d = -mag_q;
        end else begin
            prod_d = mag_q;
        end
    end

    // Datapath registers with no reset; validity lives in the sideband.
    always_ff @(posedge clk_i) begin
        if (adv) begin
            ah_q   <= ah_d;
            al_q   <= al_d;
            bh_q   <= bh_d;
            bl_q   <= bl_d;
            suma_q <= suma_d;
            sumb_q <= sumb_d;
            t_q    <= t_d;
            pla_q  <= pla_d;
            pha_q  <= pha_d;
            m_q    <= m_d;
            plb_q  <= plb_d;
            phb_q  <= phb_d;
            mag_q  <= mag_d;
        end
    end

    // Output product register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prod_q <= '0;
        end else if (adv) begin
            prod_q <= prod_d;
        end
    end

    assign ready_o   = adv;
    assign valid_o   = sb_q[NST-1].valid;
    assign tag_o     = sb_q[NST-1].tag;
    assign product_o = prod_q;

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Scoreboard bench: two instances (24-bit/LAT 2 and 25-bit/LAT 3).
module tb_karatsuba_mult_pipe;

    localparam int unsigned W1 = 24;
    localparam int unsigned W2 = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic            v_i1, r_o1, s_i1, v_o1, r_i1;
    logic [3:0]      t_i1, t_o1;
    logic [W1-1:0]   a1, b1;
    logic [2*W1-1:0] p_o1;

    logic            v_i2, r_o2, s_i2, v_o2, r_i2;
    logic [3:0]      t_i2, t_o2;
    logic [W2-1:0]   a2, b2;
    logic [2*W2-1:0] p_o2;

    karatsuba_mult_pipe #(.WIDTH(W1), .LEAF_LAT(2), .TAG_W(4)) u_dut1 (
        .clk_i (clk), .rstn_i (rstn), .valid_i (v_i1), .ready_o (r_o1),
        .signed_i (s_i1), .tag_i (t_i1), .multiplicand_i (a1), .multiplier_i (b1),
        .valid_o (v_o1), .ready_i (r_i1), .tag_o (t_o1), .product_o (p_o1)
    );

    karatsuba_mult_pipe #(.WIDTH(W2), .LEAF_LAT(3), .TAG_W(4)) u_dut2 (
        .clk_i (clk), .rstn_i (rstn), .valid_i (v_i2), .ready_o (r_o2),
        .signed_i (s_i2), .tag_i (t_i2), .multiplicand_i (a2), .multiplier_i (b2),
        .valid_o (v_o2), .ready_i (r_i2), .tag_o (t_o2), .product_o (p_o2)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] prod;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int out2_cnt = 0, out2_first = 0, out2_last = 0;
    bit rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference: sign-extend within w bits, multiply, keep 2w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic s, input int w);
        logic signed [63:0] sa, sb, p;
        sa = a;
        sb = b;
        if (s && a[w-1]) sa = sa - (64'sd1 << w);
        if (s && b[w-1]) sb = sb - (64'sd1 << w);
        p = sa * sb;
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor for instance 1: compare head of queue whenever valid_o is up.
    always @(negedge clk) begin
        if (rstn) begin
            chk("ready_o1", 64'(r_o1), 64'(!v_o1 || r_i1));
            if (v_o1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out1_unexpected: got tag %h product %h, required none",
                             t_o1, p_o1);
                end else begin
                    chk("product1", 64'(p_o1), q1[0].prod);
                    chk("tag1", 64'(t_o1), 64'(q1[0].tag));
                    if (r_i1) void'(q1.pop_front());
                end
            end
        end
    end

    // Monitor for instance 2, also recording output cycles for throughput.
    always @(negedge clk) begin
        if (rstn && v_o2) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out2_unexpected: got tag %h product %h, required none",
                         t_o2, p_o2);
            end else begin
                chk("product2", 64'(p_o2), q2[0].prod);
                chk("tag2", 64'(t_o2), 64'(q2[0].tag));
                if (r_i2) begin
                    void'(q2.pop_front());
                    if (out2_cnt == 0) out2_first = cyc;
                    out2_last = cyc;
                    out2_cnt++;
                end
            end
        end
    end

    // Downstream ready: pseudo-random when enabled, otherwise always ready.
    initial begin
        r_i1 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            r_i1 = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic s,
                         input logic [3:0] t, input logic [63:0] e, output int acc);
        a1 = a; b1 = b; s_i1 = s; t_i1 = t; v_i1 = 1'b1;
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (r_o1) begin
                acc = cyc;
                q1.push_back('{tag: t, prod: e});
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send1_timeout: got no accept, required accept for tag %h", t);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic s,
                         input logic [3:0] t, input logic [63:0] e, output int acc);
        a2 = a; b2 = b; s_i2 = s; t_i2 = t; v_i2 = 1'b1;
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (r_o2) begin
                acc = cyc;
                q2.push_back('{tag: t, prod: e});
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send2_timeout: got no accept, required accept for tag %h", t);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input bit which, output int c);
        c = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if ((which == 1'b0) ? v_o1 : v_o2) begin
                c = cyc;
                break;
            end
        end
        #1;
    endtask

    task automatic drain(input bit which);
        for (int n = 0; n < 3000; n++) begin
            if (((which == 1'b0) ? q1.size() : q2.size()) == 0) break;
            @(posedge clk);
        end
        chk(which ? "drain2_left" : "drain1_left",
            64'((which == 1'b0) ? q1.size() : q2.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, c;
        logic [W1-1:0] ra, rb;
        logic [W2-1:0] xa, xb;
        logic rs;

        rstn = 1'b0;
        v_i1 = 1'b0; s_i1 = 1'b0; t_i1 = '0; a1 = '0; b1 = '0;
        v_i2 = 1'b0; s_i2 = 1'b0; t_i2 = '0; a2 = '0; b2 = '0; r_i2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // First cycle after reset release.
        @(negedge clk);
        chk("rst_valid1", 64'(v_o1), 64'd0);
        chk("rst_product1", 64'(p_o1), 64'd0);
        chk("rst_tag1", 64'(t_o1), 64'd0);
        chk("rst_ready1", 64'(r_o1), 64'd1);
        chk("rst_valid2", 64'(v_o2), 64'd0);
        chk("rst_product2", 64'(p_o2), 64'd0);
        chk("rst_ready2", 64'(r_o2), 64'd1);
        @(posedge clk);
        #1;

        // Unsigned all-ones, latency 7.
        send1(24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'h5, 64'h0000_FFFF_FE00_0001, acc);
        v_i1 = 1'b0;
        wait_valid(1'b0, c);
        chk("latency1", 64'(c - acc), 64'd7);
        drain(1'b0);

        // Signed corners and a few plain vectors, back to back.
        send1(24'h800000, 24'h800000, 1'b1, 4'h1, 64'h0000_4000_0000_0000, acc);
        send1(24'h800000, 24'h000001, 1'b1, 4'h2, 64'h0000_FFFF_FF80_0000, acc);
        send1(24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'h3, 64'h0000_0000_0000_0001, acc);
        send1(24'h000000, 24'hFFFFFF, 1'b1, 4'h4, 64'h0000_0000_0000_0000, acc);
        send1(24'h123456, 24'h000010, 1'b0, 4'h6, 64'h0000_0000_0123_4560, acc);
        send1(24'hFFFFFE, 24'h000003, 1'b1, 4'h7, 64'h0000_FFFF_FFFF_FFFA, acc);
        v_i1 = 1'b0;
        drain(1'b0);

        // Stream of 20 under random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ra = W1'($urandom);
            rb = W1'($urandom);
            rs = 1'($urandom_range(0, 1));
            send1(ra, rb, rs, 4'(i), ref_mul(64'(ra), 64'(rb), rs, W1), acc);
        end
        v_i1 = 1'b0;
        drain(1'b0);
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three in flight: nothing may emerge.
        send1(24'h000011, 24'h000022, 1'b0, 4'hA, 64'h242, acc);
        send1(24'h000033, 24'h000044, 1'b0, 4'hB, 64'hD8C, acc);
        send1(24'h000055, 24'h000066, 1'b0, 4'hC, 64'h21DE, acc);
        v_i1 = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q1.delete();
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("flushed_valid1", 64'(v_o1), 64'd0);
        end
        @(posedge clk);
        #1;

        // 25-bit, LEAF_LAT 3: latency 8.
        send2(25'h1FFFFFF, 25'h1FFFFFF, 1'b0, 4'h9, 64'h0003_FFFF_FC00_0001, acc);
        v_i2 = 1'b0;
        wait_valid(1'b1, c);
        chk("latency2", 64'(c - acc), 64'd8);
        drain(1'b1);

        // Back-to-back mixed-mode batch at full throughput.
        out2_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            xa = W2'($urandom);
            xb = W2'($urandom);
            if (i == 0) begin xa = 25'h1000000; xb = 25'h1000000; end
            if (i == 1) begin xa = 25'h1000000; xb = 25'h0000001; end
            rs = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            send2(xa, xb, rs, 4'(i), ref_mul(64'(xa), 64'(xb), rs, W2), acc);
        end
        v_i2 = 1'b0;
        drain(1'b1);
        chk("out2_count", 64'(out2_cnt), 64'd200);
        chk("throughput2", 64'(out2_last - out2_first), 64'd199);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
